if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage for the 5-stage pipelined LoongArch core. It replaces the IF state of the multi-cycle controller and feeds the decode stage (ID).
- Generates nextpc (pre-IF), drives the synchronous instruction SRAM and holds the fetched PC and instruction.
- Hands {inst, pc} to ID over a valid/allowin handshake.
- Takes branch redirects from ID and buffers one instruction while ID stalls.

Parameters:
RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset
FS_TO_DS_W, 64, width of the IF->ID bus, {inst[31:0], pc[31:0]}

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ds_allowin  input  1  ID can accept an instruction this cycle
br_taken  input  1  one-cycle redirect pulse from ID; valid only for a resolved taken branch or jump
br_target  input  32  redirect address, sampled when br_taken=1
fs_to_ds_valid  output  1  IF holds a valid instruction for ID
fs_to_ds_bus  output  64  {fs_inst, fs_pc}
inst_sram_en  output  1  SRAM read enable
inst_sram_we  output  1  tied 0
inst_sram_addr  output  32  fetch address (= nextpc)
inst_sram_wdata  output  32  tied 0
inst_sram_rdata  input  32  SRAM read data; valid the cycle after an enabled read

Behaviour:
- Pre-IF (combinational):
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4, modulo 2^32 (wraps).
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | ds_allowin | br_taken.
  - fs_to_ds_valid = fs_valid & ~br_taken.
  - A transfer to ID occurs when fs_to_ds_valid & ds_allowin.
- Registers:
  - fs_valid: 0 on reset; loads to_fs_valid when fs_allowin=1, otherwise holds.
  - fs_pc: RESET_PC-4 on reset, so the first nextpc is RESET_PC; loads nextpc when to_fs_valid & fs_allowin.
  - rdata_fresh: 0 on reset; each cycle takes the value of inst_sram_en, marking the cycle in which inst_sram_rdata belongs to fs_pc.
- Instruction buffer (inst_buf[31:0], inst_buf_valid):
  - Capture: when fs_valid & rdata_fresh & ~ds_allowin & ~br_taken & ~inst_buf_valid, set inst_buf <= inst_sram_rdata and inst_buf_valid <= 1.
  - Clear: when (fs_valid & ds_allowin) or br_taken or reset.
  - fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - No correctness may depend on SRAM output hold behaviour while en=0.
- Branch redirect:
  - br_taken overrides a stall. The instruction in IF is wrong-path: it is never presented and the buffer is dropped.
  - br_target is fetched in the same cycle; the target instruction is valid in IF next cycle.
  - br_taken during reset is ignored.
- Reset mid-operation: fs_valid and inst_buf_valid clear next edge; inst_sram_en=0 while reset=1; fetch resumes at RESET_PC the first cycle after reset deasserts.
- Output reset values:
  - inst_sram_en=0 while reset=1.
  - fs_to_ds_valid=0 after reset.
  - fs_to_ds_bus pc field = RESET_PC-4.
  - inst_sram_we=0 and inst_sram_wdata=0 always.
- Latency: nextpc is presented in cycle t; {inst, pc} is valid to ID in cycle t+1; throughput is 1 instruction/cycle when ds_allowin=1.
- Alignment: br_target[1:0] is not checked or corrected. ADEF detection belongs to a later block.

Test Plan:
- Reset release, ds_allowin=1, SRAM image word[i]=i -> addr sequence 1c000000, 1c000004, 1c000008; bus pc matches one cycle later; inst = 0, 1, 2; no bubbles.
- ds_allowin=0 for 3 cycles while IF holds pc 1c000008, SRAM output corrupted after the first cycle -> fs_to_ds_valid stays 1; bus {inst=2, pc=1c000008} stable; inst_sram_en=0; after release, next pc 1c00000c.
- br_taken=1, br_target=1c000100 while IF holds 1c000004 -> fs_to_ds_valid=0 that cycle; addr=1c000100; next cycle bus pc=1c000100; 1c000004 never transferred.
- br_taken during an ID stall with inst_buf_valid=1 -> buffer cleared; target fetched; the stale buffered instruction never appears.
- Reset asserted mid-stream at pc 1c000010 for 2 cycles -> fs_to_ds_valid=0 next edge; inst_sram_en=0; restart at 1c000000.
- fs_pc=FFFFFFFC, no branch -> nextpc wraps to 00000000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF nextpc generation, sync instruction SRAM access, {inst, pc} hand-off to ID.
// Latency: nextpc presented in cycle t, {inst, pc} valid to ID in cycle t+1; 1 instr/cycle when ID accepts.
// Backpressure: ds_allowin=0 holds fs_pc, stops SRAM reads and parks the fetched word in a 1-entry buffer.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
   parameter int          FS_TO_DS_W = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ds_allowin,
   input  logic                  br_taken,
   input  logic [31:0]           br_target,
   output logic                  fs_to_ds_valid,
   output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
   output logic                  inst_sram_en,
   output logic                  inst_sram_we,
   output logic [31:0]           inst_sram_addr,
   output logic [31:0]           inst_sram_wdata,
   input  logic [31:0]           inst_sram_rdata
);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_to_ds_t;

   logic        to_fs_valid;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic        fs_valid;
   logic        fs_allowin;
   logic        fs_ready_go;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        rdata_fresh;
   logic [31:0] inst_buf;
   logic        inst_buf_valid;
   logic        buf_capture;
   logic        buf_clear;
   fs_to_ds_t   fs_to_ds_dat;

   // Pre-IF: pick the next fetch address; a redirect from ID wins over sequential flow.
   always_comb begin
      to_fs_valid = ~reset;
      seq_pc      = fs_pc + 32'd4;
      nextpc      = br_taken ? br_target : seq_pc;
   end

   // IF handshake: a redirect always frees IF because its current instruction is wrong-path.
   always_comb begin
      fs_ready_go    = 1'b1;
      fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;
      fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
   end

   // SRAM request: read only when the result can be latched into IF next cycle.
   always_comb begin
      inst_sram_en    = to_fs_valid & fs_allowin;
      inst_sram_we    = 1'b0;
      inst_sram_addr  = nextpc;
      inst_sram_wdata = 32'd0;
   end

   // Buffer control: capture the fresh read only once while ID stalls; a hand-off or redirect drops it.
   always_comb begin
      buf_capture = fs_valid & rdata_fresh & ~ds_allowin & ~br_taken & ~inst_buf_valid;
      buf_clear   = (fs_valid & ds_allowin) | br_taken;
   end

   // Instruction source: the buffer is authoritative once filled, since SRAM output is not held.
   always_comb begin
      fs_inst           = inst_buf_valid ? inst_buf : inst_sram_rdata;
      fs_to_ds_dat.inst = fs_inst;
      fs_to_ds_dat.pc   = fs_pc;
      fs_to_ds_bus      = fs_to_ds_dat;
   end

   // IF valid bit: refills whenever IF can accept a new instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid <= 1'b0;
      end else if (fs_allowin) begin
         fs_valid <= to_fs_valid;
      end
   end

   // IF PC: reset value sits one word before RESET_PC so the first sequential fetch lands on it.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_pc <= RESET_PC - 32'd4;
      end else if (to_fs_valid & fs_allowin) begin
         fs_pc <= nextpc;
      end
   end

   // Marks the one cycle in which inst_sram_rdata belongs to fs_pc.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_fresh <= 1'b0;
      end else begin
         rdata_fresh <= inst_sram_en;
      end
   end

   // One-entry instruction buffer for ID stalls.
   always_ff @(posedge clk) begin
      if (reset || buf_clear) begin
         inst_buf_valid <= 1'b0;
      end else if (buf_capture) begin
         inst_buf_valid <= 1'b1;
         inst_buf       <= inst_sram_rdata;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural sync SRAM whose word at addr is (addr-RESET_PC)>>2.
// Latency: SRAM model returns data the cycle after an enabled read; garbage otherwise.
// Backpressure: bench drives ds_allowin directly to exercise stalls and the instruction buffer.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;
   localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

   logic        clk;
   logic        reset;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_en;
   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   int err_cnt;
   int chk_cnt;

   if_stage #(
      .RESET_PC   (RESET_PC),
      .FS_TO_DS_W (64)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ds_allowin      (ds_allowin),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_to_ds_bus    (fs_to_ds_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] addr);
      logic [31:0] d;
      d = addr - RESET_PC;
      return d >> 2;
   endfunction

   // Sync SRAM model: output is only meaningful after an enabled read.
   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= img(inst_sram_addr);
      else              inst_sram_rdata <= GARBAGE;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after changing inputs mid-cycle.
   task automatic settle();
      #1;
   endtask

   task automatic chk_bus(input string tag, input logic [31:0] inst, input logic [31:0] pc);
      chk({tag, "_valid"}, {63'd0, fs_to_ds_valid}, 64'd1);
      chk({tag, "_bus"}, fs_to_ds_bus, {inst, pc});
   endtask

   initial begin
      err_cnt    = 0;
      chk_cnt    = 0;
      reset      = 1'b1;
      ds_allowin = 1'b1;
      br_taken   = 1'b0;
      br_target  = 32'd0;

      // Reset state.
      cyc(); cyc();
      settle();
      chk("rst_en", {63'd0, inst_sram_en}, 64'd0);
      chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      chk("rst_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, RESET_PC - 32'd4});
      chk("rst_we", {63'd0, inst_sram_we}, 64'd0);
      chk("rst_wdata", {32'd0, inst_sram_wdata}, 64'd0);

      // Reset release: streaming at one instruction per cycle.
      reset = 1'b0;
      settle();
      chk("start_en", {63'd0, inst_sram_en}, 64'd1);
      chk("start_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk_bus("stream", i, RESET_PC + 32'(4 * i));
         chk("stream_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC + 32'(4 * (i + 1))});
      end

      // ID stall while IF holds 1c000008; SRAM output becomes garbage after one cycle.
      cyc();
      ds_allowin = 1'b0;
      settle();
      chk_bus("stall0", 32'd2, RESET_PC + 32'h8);
      chk("stall0_en", {63'd0, inst_sram_en}, 64'd0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk_bus("stall", 32'd2, RESET_PC + 32'h8);
         chk("stall_en", {63'd0, inst_sram_en}, 64'd0);
      end
      ds_allowin = 1'b1;
      settle();
      chk_bus("release", 32'd2, RESET_PC + 32'h8);
      chk("release_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC + 32'hc});
      cyc();
      chk_bus("after_stall", 32'd3, RESET_PC + 32'hc);
      cyc();
      chk_bus("pre_reset", 32'd4, RESET_PC + 32'h10);

      // Mid-stream reset for two cycles; a redirect during reset must be ignored.
      reset = 1'b1;
      settle();
      chk("mid_rst_en", {63'd0, inst_sram_en}, 64'd0);
      cyc();
      chk("mid_rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      br_taken  = 1'b1;
      br_target = 32'h1c00_0200;
      settle();
      chk("mid_rst_en2", {63'd0, inst_sram_en}, 64'd0);
      cyc();
      reset    = 1'b0;
      br_taken = 1'b0;
      settle();
      chk("restart_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      chk("restart_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
      cyc();
      chk_bus("restart0", 32'd0, RESET_PC);
      cyc();

      // Redirect while IF holds 1c000004: that instruction is never presented.
      br_taken  = 1'b1;
      br_target = 32'h1c00_0100;
      settle();
      chk("br_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      chk("br_en", {63'd0, inst_sram_en}, 64'd1);
      chk("br_addr", {32'd0, inst_sram_addr}, 64'h1c00_0100);
      cyc();
      br_taken = 1'b0;
      settle();
      chk_bus("br_tgt", 32'h40, 32'h1c00_0100);
      chk("br_seq_addr", {32'd0, inst_sram_addr}, 64'h1c00_0104);

      // Redirect during an ID stall with a buffered instruction.
      ds_allowin = 1'b0;
      settle();
      chk_bus("bstall0", 32'h40, 32'h1c00_0100);
      cyc();
      chk_bus("bstall1", 32'h40, 32'h1c00_0100);
      br_taken  = 1'b1;
      br_target = 32'h1c00_0200;
      settle();
      chk("bbr_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      chk("bbr_addr", {32'd0, inst_sram_addr}, 64'h1c00_0200);
      chk("bbr_en", {63'd0, inst_sram_en}, 64'd1);
      cyc();
      br_taken = 1'b0;
      settle();
      chk_bus("bbr_tgt", 32'h80, 32'h1c00_0200);
      cyc();
      chk_bus("bbr_hold", 32'h80, 32'h1c00_0200);
      ds_allowin = 1'b1;
      settle();
      chk("bbr_rel_addr", {32'd0, inst_sram_addr}, 64'h1c00_0204);
      cyc();
      chk_bus("bbr_next", 32'h81, 32'h1c00_0204);

      // PC wrap at the top of the address space.
      br_taken  = 1'b1;
      br_target = 32'hffff_fffc;
      settle();
      chk("wrap_br_addr", {32'd0, inst_sram_addr}, 64'hffff_fffc);
      cyc();
      br_taken = 1'b0;
      settle();
      chk_bus("wrap_top", img(32'hffff_fffc), 32'hffff_fffc);
      chk("wrap_addr", {32'd0, inst_sram_addr}, 64'd0);
      cyc();
      chk_bus("wrap_zero", img(32'd0), 32'd0);
      chk("end_we", {63'd0, inst_sram_we}, 64'd0);
      chk("end_wdata", {32'd0, inst_sram_wdata}, 64'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
